// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: registered round-robin arbiter for eight requesters.
//
// The winner is the first requester at or after (last + 1) mod 8. A grant is
// held until the owner drops its request, or until MAX_HOLD granted cycles
// have elapsed (MAX_HOLD = 0 disables this). Every ownership change passes
// through one idle cycle with no grant.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req       request vector, bit n = requester n
//   gnt       one-hot grant, zero when idle (decode of gnt_idx)
//   gnt_idx   index of the current owner, 0 when idle
//   gnt_valid high while a grant is active
//   preempt   one-cycle pulse in the gap cycle after a hold-limit expiry
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // hold_cnt starts at 0 in the first granted cycle, so the owner is dropped
  // when the count reaches MAX_HOLD - 1.
  localparam bit        HoldEn   = (MAX_HOLD != 0);
  localparam logic [7:0] HoldLast = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       preempt_q, preempt_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [2:0] winner;

  // Scan from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    winner = 3'd0;
    for (int unsigned i = 8; i >= 1; i--) begin
      if (req[last_q + 3'(i)]) begin
        winner = last_q + 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        gnt_d       = 8'd0;
        gnt_idx_d   = 3'd0;
        gnt_valid_d = 1'b0;
        if (req != 8'd0) begin
          state_d     = StGrant;
          gnt_d       = 8'd1 << winner;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
          last_d      = winner;
          hold_cnt_d  = 8'd0;
        end
      end
      StGrant: begin
        if (!req[gnt_idx_q]) begin
          // Release wins over a coincident expiry; no preempt pulse.
          state_d     = StIdle;
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
        end else if (HoldEn && (hold_cnt_q == HoldLast)) begin
          state_d     = StIdle;
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          preempt_d   = 1'b1;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      last_q      <= 3'd7;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: three instances (MAX_HOLD = 16, 4, 3) checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, req_b, req_c;
  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;
  logic       pre_a, pre_b, pre_c;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a),
    .gnt_valid(val_a), .preempt(pre_a)
  );
  rr_arbiter_8 #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b),
    .gnt_valid(val_b), .preempt(pre_b)
  );
  rr_arbiter_8 #(.MAX_HOLD(3)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c),
    .gnt_valid(val_c), .preempt(pre_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: owner = -1 when idle, held = granted cycles so far.
  typedef struct {
    int owner;
    int last;
    int held;
    bit pre;
  } mstate_t;

  mstate_t ms_a, ms_b, ms_c;
  bit armed = 1'b0;

  function automatic mstate_t model_step(mstate_t s, logic [7:0] r, logic rs, int mh);
    mstate_t n;
    bit found;
    n = s;
    n.pre = 1'b0;
    if (rs) begin
      n.owner = -1;
      n.last  = 7;
      n.held  = 0;
    end else if (s.owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && r[(s.last + k) % 8]) begin
          found   = 1'b1;
          n.owner = (s.last + k) % 8;
          n.last  = n.owner;
          n.held  = 1;
        end
      end
    end else if (!r[s.owner]) begin
      n.owner = -1;
    end else if (mh != 0 && s.held == mh) begin
      n.owner = -1;
      n.pre   = 1'b1;
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ms_a = model_step(ms_a, req_a, rst, 16);
    ms_b = model_step(ms_b, req_b, rst, 4);
    ms_c = model_step(ms_c, req_c, rst, 3);
    if (rst) armed = 1'b1;
  end

  task automatic cmp_model(string name, mstate_t s, logic [7:0] g, logic [2:0] gi,
                           logic gv, logic p);
    logic [7:0] eg;
    logic [2:0] ei;
    logic       ev;
    eg = (s.owner >= 0) ? (8'd1 << s.owner) : 8'd0;
    ei = (s.owner >= 0) ? 3'(s.owner) : 3'd0;
    ev = (s.owner >= 0);
    checks++;
    if (g !== eg || gi !== ei || gv !== ev || p !== s.pre) begin
      errors++;
      $display("FAIL model_%s t=%0t actual gnt=%h idx=%0d valid=%b pre=%b expected gnt=%h idx=%0d valid=%b pre=%b",
               name, $time, g, gi, gv, p, eg, ei, ev, s.pre);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_model("a", ms_a, gnt_a, idx_a, val_a, pre_a);
      cmp_model("b", ms_b, gnt_b, idx_b, val_b, pre_b);
      cmp_model("c", ms_c, gnt_c, idx_c, val_c, pre_c);
    end
  end

  task automatic lit(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    ms_a = '{owner: -1, last: 7, held: 0, pre: 1'b0};
    ms_b = ms_a;
    ms_c = ms_a;
    rst   = 1'b1;
    req_a = 8'hFF;
    req_b = 8'h00;
    req_c = 8'h00;

    // Reset with all requests high.
    step();
    step();
    lit("rst_gnt", gnt_a, 8'h00);
    lit("rst_valid", {7'd0, val_a}, 8'h00);
    lit("rst_preempt", {7'd0, pre_a}, 8'h00);
    rst = 1'b0;
    step();
    lit("first_gnt", gnt_a, 8'h01);

    // Rotation: each owner holds two cycles, drops for one.
    for (int n = 0; n < 8; n++) begin
      lit("rot_gnt1", gnt_a, 8'd1 << n);
      step();
      lit("rot_gnt2", gnt_a, 8'd1 << n);
      req_a = ~(8'd1 << n);
      step();
      lit("rot_gap", gnt_a, 8'h00);
      req_a = 8'hFF;
      step();
    end
    lit("rot_wrap", gnt_a, 8'h01);

    // Wrap and skip: last = 6, then requesters 0 and 5.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 8'h40;
    step();
    lit("ws_own6", gnt_a, 8'h40);
    req_a = 8'b0010_0001;
    step();
    lit("ws_gap", gnt_a, 8'h00);
    step();
    lit("ws_gnt0", gnt_a, 8'h01);
    req_a = 8'h20;
    step();
    lit("ws_gap2", gnt_a, 8'h00);
    step();
    lit("ws_gnt5", gnt_a, 8'h20);
    lit("ws_idx5", {5'd0, idx_a}, 8'h05);
    req_a = 8'h00;

    // Preemption with MAX_HOLD = 4.
    req_b = 8'h0C;
    step();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        lit("pre4_gnt2", gnt_b, 8'h04);
        step();
      end
      lit("pre4_gap", gnt_b, 8'h00);
      lit("pre4_pulse", {7'd0, pre_b}, 8'h01);
      step();
      for (int i = 0; i < 4; i++) begin
        lit("pre4_gnt3", gnt_b, 8'h08);
        lit("pre4_nopulse", {7'd0, pre_b}, 8'h00);
        step();
      end
      lit("pre4_gap2", gnt_b, 8'h00);
      lit("pre4_pulse2", {7'd0, pre_b}, 8'h01);
      step();
    end
    lit("pre4_back", gnt_b, 8'h04);
    req_b = 8'h00;

    // Sole requester with MAX_HOLD = 3.
    req_c = 8'h10;
    step();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        lit("sole_gnt", gnt_c, 8'h10);
        lit("sole_valid", {7'd0, val_c}, 8'h01);
        step();
      end
      lit("sole_gap", gnt_c, 8'h00);
      lit("sole_pulse", {7'd0, pre_c}, 8'h01);
      step();
    end
    req_c = 8'h00;
    step();
    step();

    // Reset in the middle of a grant.
    req_a = 8'h08;
    step();
    lit("mid_own3", gnt_a, 8'h08);
    step();
    rst = 1'b1;
    step();
    lit("mid_rst_gnt", gnt_a, 8'h00);
    lit("mid_rst_idx", {5'd0, idx_a}, 8'h00);
    rst = 1'b0;
    step();
    lit("mid_regrant", gnt_a, 8'h08);
    lit("mid_regrant_idx", {5'd0, idx_a}, 8'h03);
    req_a = 8'h00;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
